// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder.
package mem_resp_pkg;

    localparam int WORD_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [63:0]           addr;
        logic                  we;
        logic [63:0]           wdata;
        logic [WORD_BYTES-1:0] wmask;
    } req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the MMU channels and the memory responder.
interface mem_responder_if;
    logic        if_request;
    logic [63:0] if_addr;
    logic [31:0] if_data;
    logic        if_valid;
    logic        if_busy;
    logic        mem_en;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;
    logic        mem_valid;
    logic        mem_busy;
    logic        overrun;

    modport slave (
        input  if_request, if_addr, mem_en, mem_addr, mem_we, mem_wdata, mem_wmask,
        output if_data, if_valid, if_busy, mem_rdata, mem_valid, mem_busy, overrun
    );

    modport master (
        output if_request, if_addr, mem_en, mem_addr, mem_we, mem_wdata, mem_wmask,
        input  if_data, if_valid, if_busy, mem_rdata, mem_valid, mem_busy, overrun
    );
endinterface

// File: rtl/mem_resp_ram.sv
// Single-port 64-bit RAM: synchronous byte-masked write, synchronous read.
module mem_resp_ram
    import mem_resp_pkg::*;
#(
    parameter int MEM_DEPTH     = 4096,
    parameter int AW            = $clog2(MEM_DEPTH),
    parameter     MEM_INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [63:0]           wdata,
    input  logic [WORD_BYTES-1:0] wmask,
    output logic [63:0]           rdata
);

    logic [63:0] mem [MEM_DEPTH];

    // One access per enable: masked write, or read into the output register.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < WORD_BYTES; b++) begin
                    if (wmask[b]) begin
                        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: one pending slot per channel, data-priority arbiter,
// fixed-latency access to a shared RAM and one-cycle response pulses.
//
// state  | meaning
// IDLE   | waiting for a valid slot; data slot wins over fetch
// ACCESS | counting down the RAM latency; op happens when cnt reaches 0
// RESP   | one-cycle valid pulse for the granted channel
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int MEM_DEPTH     = 4096,
    parameter int LATENCY       = 2,
    parameter     MEM_INIT_FILE = ""
) (
    input logic             clk,
    input logic             rst,
    mem_responder_if.slave  bus
);

    localparam int AW = $clog2(MEM_DEPTH);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_data_q, gnt_data_d;
    req_t        req_q, req_d;
    logic        if_slot_vld_q, if_slot_vld_d;
    logic [63:0] if_slot_addr_q, if_slot_addr_d;
    logic        mem_slot_vld_q, mem_slot_vld_d;
    req_t        mem_slot_q, mem_slot_d;
    logic        overrun_q, overrun_d;
    logic [31:0] if_data_q, if_data_d;
    logic [63:0] mem_rdata_q, mem_rdata_d;

    logic        ram_op;
    logic        clear_if;
    logic        clear_mem;
    logic        resp_if;
    logic        resp_mem;
    logic        resp_load;
    logic [63:0] ram_rdata;
    logic [31:0] fetch_half;
    logic        unused_addr_bits;

    // The granted request is copied at grant time, so slots may refill freely
    // once they clear on the edge entering RESP.
    assign ram_op    = (state_q == ACCESS) && (cnt_q == '0);
    assign clear_if  = ram_op && !gnt_data_q;
    assign clear_mem = ram_op && gnt_data_q;
    assign resp_if   = (state_q == RESP) && !gnt_data_q;
    assign resp_mem  = (state_q == RESP) && gnt_data_q;
    assign resp_load = resp_mem && !req_q.we;

    assign fetch_half       = req_q.addr[2] ? ram_rdata[63:32] : ram_rdata[31:0];
    assign unused_addr_bits = ^{req_q.addr[63:AW+3], req_q.addr[1:0]};

    // Slot capture, clear and overrun; a capture on the clearing edge wins.
    always_comb begin
        if_slot_vld_d  = if_slot_vld_q;
        if_slot_addr_d = if_slot_addr_q;
        mem_slot_vld_d = mem_slot_vld_q;
        mem_slot_d     = mem_slot_q;
        overrun_d      = overrun_q;

        if (clear_if) begin
            if_slot_vld_d = 1'b0;
        end
        if (clear_mem) begin
            mem_slot_vld_d = 1'b0;
        end

        if (bus.if_request) begin
            if (!if_slot_vld_q || clear_if) begin
                if_slot_vld_d  = 1'b1;
                if_slot_addr_d = bus.if_addr;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (bus.mem_en) begin
            if (!mem_slot_vld_q || clear_mem) begin
                mem_slot_vld_d = 1'b1;
                mem_slot_d     = '{addr: bus.mem_addr, we: bus.mem_we,
                                   wdata: bus.mem_wdata, wmask: bus.mem_wmask};
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Arbiter, latency counter and state sequencing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_data_d = gnt_data_q;
        req_d      = req_q;

        case (state_q)
            IDLE: begin
                if (mem_slot_vld_q) begin
                    state_d    = ACCESS;
                    cnt_d      = 4'(LATENCY - 1);
                    gnt_data_d = 1'b1;
                    req_d      = mem_slot_q;
                end else if (if_slot_vld_q) begin
                    state_d    = ACCESS;
                    cnt_d      = 4'(LATENCY - 1);
                    gnt_data_d = 1'b0;
                    req_d      = '{addr: if_slot_addr_q, we: 1'b0, wdata: '0, wmask: '0};
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response data holds the last value delivered on each channel.
    always_comb begin
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if (resp_if) begin
            if_data_d = fetch_half;
        end
        if (resp_load) begin
            mem_rdata_d = ram_rdata;
        end
    end

    // State and slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            gnt_data_q     <= 1'b0;
            req_q          <= '0;
            if_slot_vld_q  <= 1'b0;
            if_slot_addr_q <= '0;
            mem_slot_vld_q <= 1'b0;
            mem_slot_q     <= '0;
            overrun_q      <= 1'b0;
            if_data_q      <= '0;
            mem_rdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            gnt_data_q     <= gnt_data_d;
            req_q          <= req_d;
            if_slot_vld_q  <= if_slot_vld_d;
            if_slot_addr_q <= if_slot_addr_d;
            mem_slot_vld_q <= mem_slot_vld_d;
            mem_slot_q     <= mem_slot_d;
            overrun_q      <= overrun_d;
            if_data_q      <= if_data_d;
            mem_rdata_q    <= mem_rdata_d;
        end
    end

    // Gating the enable with rst keeps a reset on the op edge from writing.
    mem_resp_ram #(
        .MEM_DEPTH    (MEM_DEPTH),
        .AW           (AW),
        .MEM_INIT_FILE(MEM_INIT_FILE)
    ) u_ram (
        .clk  (clk),
        .en   (ram_op && !rst),
        .we   (req_q.we),
        .addr (req_q.addr[AW+2:3]),
        .wdata(req_q.wdata),
        .wmask(req_q.wmask),
        .rdata(ram_rdata)
    );

    // The response register is bypassed during RESP so data and valid align.
    assign bus.if_data   = resp_if ? fetch_half : if_data_q;
    assign bus.mem_rdata = resp_load ? ram_rdata : mem_rdata_q;
    assign bus.if_valid  = resp_if;
    assign bus.mem_valid = resp_mem;
    assign bus.if_busy   = if_slot_vld_q;
    assign bus.mem_busy  = mem_slot_vld_q;
    assign bus.overrun   = overrun_q;

endmodule
